// File: rtl/img_host_link.sv
// Host-side link: loads an image into data memory, requests a processor run over the
// status handshake, then streams the result region back out one byte at a time.
module img_host_link #(
  parameter int IMG_SIZE = 65536,
  parameter int OUT_SIZE = 16384,
  parameter int OUT_BASE = 0,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              dm_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [7:0]        dm_rdata,
  output logic [1:0]        host_status,
  input  logic [1:0]        proc_status,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     IMG_LAST = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0]     OUT_LAST = CW'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(OUT_BASE);

  typedef enum logic [2:0] {LOAD, START, RUN, RD_REQ, RD_CAP, RD_OUT, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]        dm_wdata_q, dm_wdata_d, out_data_q, out_data_d;
  logic              dm_we_q, dm_we_d, dm_re_q, dm_re_d, dm_sel_q, dm_sel_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d, done_q, done_d;
  logic [1:0]        host_status_q, host_status_d;
  logic              accept;

  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = (state_q == LOAD) && in_ready_q && in_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_we_d     = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          dm_we_d    = 1'b1;
          dm_addr_d  = cnt_q[ADDR_W-1:0];
          dm_wdata_d = in_data;
          cnt_d      = cnt_inc;
          if (cnt_q == IMG_LAST) state_d = START;
        end
      end
      START: if (proc_status == 2'b10) state_d = RUN;
      RUN: begin
        if (proc_status == 2'b00) begin
          state_d   = RD_REQ;
          cnt_d     = '0;
          dm_addr_d = BASE_A;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        out_data_d  = dm_rdata;
        out_valid_d = 1'b1;
        state_d     = RD_OUT;
      end
      RD_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (cnt_q == OUT_LAST) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            dm_addr_d = BASE_A + cnt_inc[ADDR_W-1:0];
          end
        end
      end
      FIN: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    // Outputs are registered from the next state; the last image write keeps dm_sel high
    // for its own cycle even though the state has already moved to START.
    in_ready_d    = (state_d == LOAD);
    host_status_d = (state_d == START) ? 2'b01 : 2'b00;
    dm_sel_d      = !((state_d == START) || (state_d == RUN)) || dm_we_d;
    dm_re_d       = (state_d == RD_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      dm_we_q       <= 1'b0;
      dm_re_q       <= 1'b0;
      dm_sel_q      <= 1'b1;
      in_ready_q    <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      host_status_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      dm_we_q       <= dm_we_d;
      dm_re_q       <= dm_re_d;
      dm_sel_q      <= dm_sel_d;
      in_ready_q    <= in_ready_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
      host_status_q <= host_status_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign dm_sel      = dm_sel_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign dm_we       = dm_we_q;
  assign dm_re       = dm_re_q;
  assign host_status = host_status_q;
  assign done        = done_q;

endmodule

// File: tb/tb_img_host_link.sv
// Directed bench for img_host_link: 16-byte load, status handshake, 4-byte readback
// from address 16 with backpressure, and resets in the middle of load and readback.
module tb_img_host_link;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       dm_sel;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       dm_we;
  logic       dm_re;
  logic [7:0] dm_rdata = 8'h00;
  logic [1:0] host_status;
  logic [1:0] proc_status = 2'b00;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0};

  img_host_link #(.IMG_SIZE(16), .OUT_SIZE(4), .OUT_BASE(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .host_status(host_status), .proc_status(proc_status), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory preloaded with 0xA0.. at addresses 16..19; read data one cycle after dm_re.
  always @(posedge clk) begin
    if (dm_sel && dm_re)
      dm_rdata <= (dm_addr >= 8'd16 && dm_addr < 8'd20) ? 8'hA0 + (dm_addr - 8'd16) : 8'hEE;
  end

  // Bus rules: no strobe while the processor owns memory, never both strobes at once.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (((dm_we || dm_re) && !dm_sel) || (dm_we && dm_re)) begin
        miscompares++;
        $display("FAIL bus_rule: we=%b re=%b sel=%b, required no strobe without sel and not both",
                 dm_we, dm_re, dm_sel);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done} !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h",
               {in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done}, RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_load(input logic [7:0] base, input int n);
    int cyc;
    cyc = 0;
    in_valid = 1'b0;
    while (!in_ready && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = base;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if ({dm_we, dm_sel, dm_addr, dm_wdata} !== {1'b1, 1'b1, 8'(i), base + 8'(i)}) begin
        miscompares++;
        $display("FAIL load_write[%0d]: we=%b sel=%b addr=%h data=%h want 1 1 %h %h",
                 i, dm_we, dm_sel, dm_addr, dm_wdata, 8'(i), base + 8'(i));
      end
      vectors++;
      if ({in_ready, host_status} !== {1'(i < 15), (i == 15) ? 2'b01 : 2'b00}) begin
        miscompares++;
        $display("FAIL load_status[%0d]: in_ready=%b host=%b want %b %b",
                 i, in_ready, host_status, 1'(i < 15), (i == 15) ? 2'b01 : 2'b00);
      end
      in_data = base + 8'(i + 1);
    end
    if (n == 16) begin
      @(negedge clk);
      vectors++;
      if ({dm_we, dm_sel, host_status, in_ready} !== {1'b0, 1'b0, 2'b01, 1'b0}) begin
        miscompares++;
        $display("FAIL start_state: we=%b sel=%b host=%b in_ready=%b want 0 0 01 0",
                 dm_we, dm_sel, host_status, in_ready);
      end
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic test_handshake();
    proc_status = 2'b00;
    for (int i = 0; i < 7; i++) begin
      if (i >= 5) proc_status = 2'b11;
      @(negedge clk);
      vectors++;
      if ({host_status, dm_sel, dm_we, dm_re} !== {2'b01, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL start_hold[%0d]: host=%b sel=%b we=%b re=%b want 01 0 0 0",
                 i, host_status, dm_sel, dm_we, dm_re);
      end
    end
    proc_status = 2'b10;
    @(negedge clk);
    vectors++;
    if ({host_status, dm_sel} !== {2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL run_entry: host=%b sel=%b want 00 0", host_status, dm_sel);
    end
    for (int i = 0; i < 23; i++) begin
      proc_status = (i < 3) ? 2'b11 : 2'b10;
      @(negedge clk);
      vectors++;
      if ({host_status, dm_sel, dm_re} !== {2'b00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL run_hold[%0d]: host=%b sel=%b re=%b want 00 0 0", i, host_status, dm_sel, dm_re);
      end
    end
    in_valid = 1'b0;
    proc_status = 2'b00;
    @(negedge clk);
    vectors++;
    if ({dm_re, dm_sel, dm_addr} !== {1'b1, 1'b1, 8'd16}) begin
      miscompares++;
      $display("FAIL first_read: re=%b sel=%b addr=%h want 1 1 10", dm_re, dm_sel, dm_addr);
    end
  endtask

  task automatic test_readback(input bit stall);
    int cyc;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({dm_re, dm_sel, dm_addr, out_valid} !== {1'b1, 1'b1, 8'(16 + k), 1'b0}) begin
        miscompares++;
        $display("FAIL rd_req[%0d]: re=%b sel=%b addr=%h ov=%b want 1 1 %h 0",
                 k, dm_re, dm_sel, dm_addr, out_valid, 8'(16 + k));
      end
      out_ready = !(stall && k == 1);
      cyc = 0;
      while (!out_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      vectors++;
      if (cyc !== 2 || out_data !== 8'hA0 + 8'(k)) begin
        miscompares++;
        $display("FAIL rd_data[%0d]: latency=%0d data=%h want 2 %h", k, cyc, out_data, 8'hA0 + 8'(k));
      end
      if (stall && k == 1) begin
        repeat (7) begin
          @(negedge clk);
          vectors++;
          if ({out_valid, out_data, dm_re} !== {1'b1, 8'hA1, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold: ov=%b data=%h re=%b want 1 a1 0", out_valid, out_data, dm_re);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      vectors++;
      if ({out_valid, done} !== {1'b0, 1'(k == 3)}) begin
        miscompares++;
        $display("FAIL rd_after[%0d]: ov=%b done=%b want 0 %b", k, out_valid, done, 1'(k == 3));
      end
    end
    @(negedge clk);
    vectors++;
    if ({done, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL done_pulse_end: done=%b in_ready=%b want 0 1", done, in_ready);
    end
  endtask

  task automatic test_reset_midload();
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done} !== RESET_VEC) begin
      miscompares++;
      $display("FAIL midload_reset: got %h want %h",
               {in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done}, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_midreadback();
    int cyc;
    cyc = 0;
    out_ready = 1'b0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (out_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL abort_data: data=%h want a0", out_data);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done} !== RESET_VEC) begin
      miscompares++;
      $display("FAIL midread_reset: got %h want %h",
               {in_ready, out_valid, out_data, dm_sel, dm_addr, dm_wdata, dm_we, dm_re, host_status, done}, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load(8'h30, 16);
    test_handshake();
    test_readback(1'b1);
    test_load(8'h40, 6);
    test_reset_midload();
    test_load(8'h50, 16);
    test_handshake();
    test_readback(1'b0);
    test_load(8'h70, 16);
    test_handshake();
    test_reset_midreadback();
    test_load(8'h90, 16);
    test_handshake();
    test_readback(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
